// File: rtl/peak_abs.sv
`default_nettype none
// ============================================================================
// Module      : peak_abs
// Description : Frame-based peak |sample| detector with first-occurrence index.
// Revision    : 1.0
// ============================================================================
module peak_abs #(
    parameter int WIDTH     = 16,
    parameter int N_SAMPLES = 16,
    localparam int IW       = $clog2(N_SAMPLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] sample_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] peak_out,
    output logic [IW-1:0]    peak_idx
);

    localparam logic [0:0]    S_IDLE = 1'b0;
    localparam logic [0:0]    S_RUN  = 1'b1;
    localparam logic [IW-1:0] C_LAST = IW'(N_SAMPLES - 1);

    logic [0:0]       state_q, state_d;
    logic [IW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] peak_q, peak_d;
    logic [IW-1:0]    peak_idx_q, peak_idx_d;

    logic [WIDTH:0]   w_ext;
    logic [WIDTH:0]   w_mag;
    logic             w_gt;
    logic [WIDTH-1:0] w_new_max;
    logic [IW-1:0]    w_new_idx;

    // One extra bit so the most negative sample maps to its exact magnitude.
    always_comb begin
        w_ext     = {sample_in[WIDTH-1], sample_in};
        w_mag     = sample_in[WIDTH-1] ? (~w_ext + 1'b1) : w_ext;
        w_gt      = w_mag > {1'b0, max_q};
        w_new_max = w_gt ? w_mag[WIDTH-1:0] : max_q;
        w_new_idx = w_gt ? cnt_q : idx_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        max_d       = max_q;
        idx_d       = idx_q;
        out_valid_d = 1'b0;
        peak_d      = peak_q;
        peak_idx_d  = peak_idx_q;

        if (start) begin
            // Restart wins over any sample presented in the same cycle.
            state_d = S_RUN;
            cnt_d   = '0;
            max_d   = '0;
            idx_d   = '0;
        end else if (state_q == S_RUN && in_valid) begin
            max_d = w_new_max;
            idx_d = w_new_idx;
            if (cnt_q == C_LAST) begin
                peak_d      = w_new_max;
                peak_idx_d  = w_new_idx;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            peak_q      <= '0;
            peak_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            peak_q      <= peak_d;
            peak_idx_q  <= peak_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign peak_out  = peak_q;
    assign peak_idx  = peak_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_peak_abs.sv
`default_nettype none
// ============================================================================
// Module      : tb_peak_abs
// Description : Directed self-checking bench for peak_abs (WIDTH=16, N=16).
// Revision    : 1.0
// ============================================================================
module tb_peak_abs;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [15:0] sample_in;
    logic        out_valid;
    logic [15:0] peak_out;
    logic [3:0]  peak_idx;

    int checks   = 0;
    int failures = 0;
    int ov_count = 0;
    bit prev_ov  = 1'b0;
    bit double_ov = 1'b0;

    logic [15:0] frame [16];

    peak_abs #(.WIDTH(16), .N_SAMPLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .sample_in (sample_in),
        .out_valid (out_valid),
        .peak_out  (peak_out),
        .peak_idx  (peak_idx)
    );

    always #5 clk = ~clk;

    // Pulse counter sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (out_valid) ov_count++;
        if (out_valid && prev_ov) double_ov = 1'b1;
        prev_ov = out_valid;
    end

    task automatic load_ref();
        int v [16] = '{12, -45, 78, -300, 150, -200, 50, 0,
                       -1024, 77, 25, -999, 500, -250, 1023, -700};
        for (int i = 0; i < 16; i++) frame[i] = 16'(v[i]);
    endtask

    task automatic drive_frame(input bit gap, input bit coincident,
                               input logic [15:0] exp_peak, input logic [3:0] exp_idx,
                               input string name);
        int base;
        start = 1'b1;
        if (coincident) begin
            in_valid  = 1'b1;
            sample_in = 16'd30000;
        end
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        base     = ov_count;
        for (int i = 0; i < 16; i++) begin
            in_valid  = 1'b1;
            sample_in = frame[i];
            @(posedge clk); #1;
            in_valid  = 1'b0;
            if (gap && i < 15) begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (ov_count !== base) begin
            failures++;
            $display("FAIL %s early_pulse: pulses=%0d required=%0d", name, ov_count - base, 0);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s out_valid: got=%b required=1", name, out_valid);
        end
        checks++;
        if (peak_out !== exp_peak) begin
            failures++;
            $display("FAIL %s peak_out: got=%0d required=%0d", name, peak_out, exp_peak);
        end
        checks++;
        if (peak_idx !== exp_idx) begin
            failures++;
            $display("FAIL %s peak_idx: got=%0d required=%0d", name, peak_idx, exp_idx);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || peak_out !== exp_peak || peak_idx !== exp_idx) begin
            failures++;
            $display("FAIL %s hold_1: ov=%b peak=%0d idx=%0d required ov=0 peak=%0d idx=%0d",
                     name, out_valid, peak_out, peak_idx, exp_peak, exp_idx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; sample_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || peak_out !== 16'd0 || peak_idx !== 4'd0) begin
            failures++;
            $display("FAIL reset_state: ov=%b peak=%0d idx=%0d required 0 0 0",
                     out_valid, peak_out, peak_idx);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reference();
        load_ref();
        drive_frame(1'b0, 1'b0, 16'd1024, 4'd8, "reference");
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || peak_out !== 16'd1024 || peak_idx !== 4'd8) begin
            failures++;
            $display("FAIL reference_hold_10: ov=%b peak=%0d idx=%0d required 0 1024 8",
                     out_valid, peak_out, peak_idx);
        end
    endtask

    task automatic test_tie_extreme();
        for (int i = 0; i < 16; i++) frame[i] = 16'd0;
        frame[3] = 16'h8000;
        frame[9] = 16'h8000;
        drive_frame(1'b0, 1'b0, 16'd32768, 4'd3, "tie_extreme");
    endtask

    task automatic test_all_zero();
        for (int i = 0; i < 16; i++) frame[i] = 16'd0;
        drive_frame(1'b0, 1'b0, 16'd0, 4'd0, "all_zero");
    endtask

    task automatic test_gapped();
        load_ref();
        drive_frame(1'b1, 1'b0, 16'd1024, 4'd8, "gapped");
    endtask

    task automatic test_idle_ignore();
        int base = ov_count;
        for (int i = 0; i < 6; i++) begin
            in_valid  = (i % 2 == 0);
            sample_in = 16'd20000 + 16'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ov_count !== base || peak_out !== 16'd1024 || peak_idx !== 4'd8) begin
            failures++;
            $display("FAIL idle_ignore: pulses=%0d peak=%0d idx=%0d required 0 1024 8",
                     ov_count - base, peak_out, peak_idx);
        end
    endtask

    task automatic test_restart();
        int base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        base  = ov_count;
        for (int i = 0; i < 7; i++) begin
            in_valid  = 1'b1;
            sample_in = (i == 2) ? 16'd30000 : 16'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) frame[i] = 16'(i * 10);
        frame[15] = 16'd500;
        drive_frame(1'b0, 1'b0, 16'd500, 4'd15, "restart");
        @(negedge clk); #1;
        checks++;
        if (ov_count !== base + 1) begin
            failures++;
            $display("FAIL restart_pulse_count: got=%0d required=%0d", ov_count - base, 1);
        end
    endtask

    task automatic test_start_coincident();
        for (int i = 0; i < 16; i++) frame[i] = 16'(-(i + 1));
        frame[2] = 16'(-700);
        drive_frame(1'b0, 1'b1, 16'd700, 4'd2, "start_coincident");
    endtask

    task automatic test_async_reset();
        int base;
        // Mid-frame reset
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            sample_in = 16'd900;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || peak_out !== 16'd0 || peak_idx !== 4'd0) begin
            failures++;
            $display("FAIL reset_mid_frame: ov=%b peak=%0d idx=%0d required 0 0 0",
                     out_valid, peak_out, peak_idx);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        // Mid-out_valid reset
        load_ref();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid  = 1'b1;
            sample_in = frame[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || peak_out !== 16'd1024) begin
            failures++;
            $display("FAIL pre_reset_pulse: ov=%b peak=%0d required 1 1024", out_valid, peak_out);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || peak_out !== 16'd0 || peak_idx !== 4'd0) begin
            failures++;
            $display("FAIL reset_mid_out_valid: ov=%b peak=%0d idx=%0d required 0 0 0",
                     out_valid, peak_out, peak_idx);
        end
        @(posedge clk); #1;
        rst  = 1'b0;
        base = ov_count;
        for (int i = 0; i < 20; i++) begin
            in_valid  = 1'b1;
            sample_in = 16'd4000;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ov_count !== base || peak_out !== 16'd0) begin
            failures++;
            $display("FAIL post_reset_no_pulse: pulses=%0d peak=%0d required 0 0",
                     ov_count - base, peak_out);
        end
        drive_frame(1'b0, 1'b0, 16'd1024, 4'd8, "post_reset_frame");
    endtask

    initial begin
        test_reset();
        test_reference();
        test_tie_extreme();
        test_all_zero();
        test_gapped();
        test_idle_ignore();
        test_restart();
        test_start_coincident();
        test_async_reset();
        repeat (2) @(posedge clk);
        checks++;
        if (double_ov !== 1'b0) begin
            failures++;
            $display("FAIL double_pulse: seen=%b required=0", double_ov);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim_time=%0t required_finish_before=200000", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
